cv32e40p_alu_reconfig_ctrl_ft: RTL and testbench

//  Downstream consumer of the per-ALU/per-subunit permanent-fault flags (4 ALUs x 9 subunits).
//  Per subunit, picks the active ALUs for the voter: the lowest-index healthy ALUs, up to 3.

---
 rtl/cv32e40p_alu_reconfig_ctrl_ft.sv | 173 +++++++++++++++++
 tb/tb_cv32e40p_alu_reconfig_ctrl_ft.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_alu_reconfig_ctrl_ft.sv
// cv32e40p_alu_reconfig_ctrl_ft
// Turns per-ALU/per-subunit permanent-fault flags into voter masks and
// redundancy modes. Whenever a new fault shows up, the pipeline is stalled
// and drained, and then the mask is swapped. This way the set of voting ALUs
// never changes while an instruction is in flight.
`timescale 1ns/1ps

module cv32e40p_alu_reconfig_ctrl_ft #(
  parameter int N_ALU         = 4,
  parameter int N_SUB         = 9,
  parameter int DRAIN_TIMEOUT = 16,
  parameter int CNT_W         = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_ALU-1:0][N_SUB-1:0]    permanent_faulty_alu_i,
  input  logic                           pipe_empty_i,
  output logic                           stall_o,
  output logic [N_SUB-1:0][N_ALU-1:0]    active_mask_o,
  output logic [N_SUB-1:0][1:0]          sub_mode_o,
  output logic                           reconfig_done_o,
  output logic                           unrecoverable_o,
  output logic                           drain_timeout_o,
  output logic [CNT_W-1:0]               reconfig_count_o
);

  localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam int HW    = $clog2(N_ALU + 1);
  localparam logic [N_ALU-1:0] RESET_MASK = N_ALU'(3'b111);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SWAP   = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   timeout_hit;

  logic [TMR_W-1:0] timer_q;

  logic [N_ALU-1:0][N_SUB-1:0] seen_q, pending_q, applied_q;
  logic [N_ALU-1:0][N_SUB-1:0] new_flags, healthy_next;

  logic [N_SUB-1:0][N_ALU-1:0] mask_q, mask_d;
  logic [N_SUB-1:0][1:0]       mode_q, mode_d;
  logic                        unrec_q, unrec_d;
  logic                        tmo_q;
  logic [CNT_W-1:0]            count_q;
  logic [HW-1:0]               h_cnt;

  // Flags not yet seen are new this cycle. Healthy set as it will stand after a swap.
  always_comb begin
    new_flags    = permanent_faulty_alu_i & ~seen_q;
    healthy_next = ~(applied_q | pending_q);
  end

  // Per subunit: keep the lowest-index healthy ALUs, up to three, and derive the mode from the count
  always_comb begin
    mask_d  = '0;
    mode_d  = '0;
    unrec_d = 1'b0;
    h_cnt   = '0;
    for (int s = 0; s < N_SUB; s++) begin
      h_cnt = '0;
      for (int a = 0; a < N_ALU; a++) begin
        if (healthy_next[a][s]) begin
          if (h_cnt < HW'(3)) mask_d[s][a] = 1'b1;
          h_cnt = h_cnt + HW'(1);
        end
      end
      case (h_cnt)
        HW'(0):  mode_d[s] = 2'b11;
        HW'(1):  mode_d[s] = 2'b10;
        HW'(2):  mode_d[s] = 2'b01;
        default: mode_d[s] = 2'b00;
      endcase
      unrec_d = unrec_d | (mode_d[s] == 2'b11);
    end
  end

  // Next-state logic of the stall/drain/swap/report handshake
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pending_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (pipe_empty_i) begin
          state_d = SWAP;
        end else if (timer_q == TMR_W'(DRAIN_TIMEOUT - 1)) begin
          state_d     = SWAP;
          timeout_hit = 1'b1;
        end
      end
      SWAP: begin
        state_d = REPORT;
      end
      REPORT: begin
        // A fault landing in this very cycle also starts the next round immediately
        if ((|pending_q) || (|new_flags)) state_d = DRAIN;
        else                              state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Drain timer: zero outside DRAIN, so it starts from zero on every entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    timer_q <= '0;
    else if (state_q != DRAIN)  timer_q <= '0;
    else                        timer_q <= timer_q + TMR_W'(1);
  end

  // Fault bookkeeping: seen is sticky, pending collects new faults, applied grows at SWAP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q    <= '0;
      pending_q <= '0;
      applied_q <= '0;
    end else begin
      seen_q <= seen_q | permanent_faulty_alu_i;
      if (state_q == SWAP) begin
        applied_q <= applied_q | pending_q;
        pending_q <= new_flags;
      end else begin
        pending_q <= pending_q | new_flags;
      end
    end
  end

  // Voter mask, modes and unrecoverable flag change only on the edge that leaves SWAP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < N_SUB; s++) mask_q[s] <= RESET_MASK;
      mode_q  <= '0;
      unrec_q <= 1'b0;
    end else if (state_q == SWAP) begin
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      unrec_q <= unrec_d;
    end
  end

  // Sticky drain-timeout flag and saturating count of completed reconfigurations
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q   <= 1'b0;
      count_q <= '0;
    end else begin
      if (timeout_hit) tmo_q <= 1'b1;
      if ((state_q == REPORT) && (count_q != {CNT_W{1'b1}})) count_q <= count_q + CNT_W'(1);
    end
  end

  assign stall_o          = (state_q == DRAIN) || (state_q == SWAP);
  assign reconfig_done_o  = (state_q == REPORT);
  assign active_mask_o    = mask_q;
  assign sub_mode_o       = mode_q;
  assign unrecoverable_o  = unrec_q;
  assign drain_timeout_o  = tmo_q;
  assign reconfig_count_o = count_q;

endmodule

// File: tb/tb_cv32e40p_alu_reconfig_ctrl_ft.sv
// Testbench for cv32e40p_alu_reconfig_ctrl_ft: single-fault rounds run from a
// vector table, then hand-written sequences for the multi-cycle corner cases.
`timescale 1ns/1ps

module tb_cv32e40p_alu_reconfig_ctrl_ft;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0][8:0]  flags;
  logic             pipe_empty;
  logic             stall;
  logic [8:0][3:0]  active_mask;
  logic [8:0][1:0]  sub_mode;
  logic             done;
  logic             unrec;
  logic             tmo;
  logic [7:0]       count;

  int checks    = 0;
  int failures  = 0;
  int exp_count = 0;
  int lat, stalls, extra;

  typedef struct {
    int         alu;
    int         sub;
    logic       pe;
    int         exp_lat;
    int         exp_stall;
    logic [3:0] exp_mask;
    logic [1:0] exp_mode;
    logic       exp_unrec;
    logic       exp_tmo;
  } vec_t;

  vec_t vecs[8];

  // 100 MHz clock
  always #5 clk = ~clk;

  cv32e40p_alu_reconfig_ctrl_ft #(
    .N_ALU(4), .N_SUB(9), .DRAIN_TIMEOUT(16), .CNT_W(8)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .permanent_faulty_alu_i (flags),
    .pipe_empty_i           (pipe_empty),
    .stall_o                (stall),
    .active_mask_o          (active_mask),
    .sub_mode_o             (sub_mode),
    .reconfig_done_o        (done),
    .unrecoverable_o        (unrec),
    .drain_timeout_o        (tmo),
    .reconfig_count_o       (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int alu, input int sub, input logic pe);
    flags[alu][sub] = 1'b1;
    pipe_empty      = pe;
  endtask

  // Ticks until the done pulse (bounded); returns cycles taken and stall cycles seen
  task automatic waitDone(output int l, output int st);
    l  = 0;
    st = 0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (stall) st++;
      if (done) begin
        l = i;
        break;
      end
    end
    checkOutput("done_seen", 64'(done), 64'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // alu, sub, pipe_empty, latency, stall cycles, mask, mode, unrec, timeout
    vecs[0] = '{1, 0, 1'b1,  4,  2, 4'b1101, 2'b00, 1'b0, 1'b0};
    vecs[1] = '{0, 0, 1'b1,  4,  2, 4'b1100, 2'b01, 1'b0, 1'b0};
    vecs[2] = '{2, 0, 1'b1,  4,  2, 4'b1000, 2'b10, 1'b0, 1'b0};
    vecs[3] = '{3, 0, 1'b1,  4,  2, 4'b0000, 2'b11, 1'b1, 1'b0};
    vecs[4] = '{2, 5, 1'b0, 19, 17, 4'b1011, 2'b00, 1'b1, 1'b1};
    vecs[5] = '{0, 7, 1'b1,  4,  2, 4'b1110, 2'b00, 1'b1, 1'b1};
    vecs[6] = '{3, 8, 1'b1,  4,  2, 4'b0111, 2'b00, 1'b1, 1'b1};
    vecs[7] = '{2, 8, 1'b1,  4,  2, 4'b0011, 2'b01, 1'b1, 1'b1};

    // T1: reset and idle with no faults
    rst        = 1'b1;
    flags      = '0;
    pipe_empty = 1'b1;
    repeat (3) tick();
    checkOutput("rst_mask", 64'(active_mask), 64'h777777777);
    checkOutput("rst_stall", 64'(stall), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("t1_stall", 64'(stall), 64'd0);
      checkOutput("t1_done", 64'(done), 64'd0);
    end
    checkOutput("t1_mask", 64'(active_mask), 64'h777777777);
    checkOutput("t1_mode", 64'(sub_mode), 64'd0);
    checkOutput("t1_count", 64'(count), 64'd0);
    checkOutput("t1_unrec", 64'(unrec), 64'd0);
    checkOutput("t1_tmo", 64'(tmo), 64'd0);

    // T2-T4 plus extra subunits: one fault per round, table driven
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].alu, vecs[i].sub, vecs[i].pe);
      waitDone(lat, stalls);
      checkOutput($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      checkOutput($sformatf("v%0d_stall_cycles", i), 64'(stalls), 64'(vecs[i].exp_stall));
      checkOutput($sformatf("v%0d_stall_at_done", i), 64'(stall), 64'd0);
      checkOutput($sformatf("v%0d_mask", i), 64'(active_mask[vecs[i].sub]), 64'(vecs[i].exp_mask));
      checkOutput($sformatf("v%0d_mode", i), 64'(sub_mode[vecs[i].sub]), 64'(vecs[i].exp_mode));
      checkOutput($sformatf("v%0d_unrec", i), 64'(unrec), 64'(vecs[i].exp_unrec));
      checkOutput($sformatf("v%0d_tmo", i), 64'(tmo), 64'(vecs[i].exp_tmo));
      exp_count++;
      tick();
      checkOutput($sformatf("v%0d_done_low", i), 64'(done), 64'd0);
      checkOutput($sformatf("v%0d_count", i), 64'(count), 64'(exp_count));
      checkOutput($sformatf("v%0d_idle", i), 64'(stall), 64'd0);
      pipe_empty = 1'b1;
    end
    checkOutput("untouched_mask1", 64'(active_mask[1]), 64'h7);

    // T5: second fault on the same subunit arrives during DRAIN -> one round
    applyStimulus(0, 3, 1'b0);
    tick();
    checkOutput("t5a_idle_first", 64'(stall), 64'd0);
    tick();
    checkOutput("t5a_in_drain", 64'(stall), 64'd1);
    applyStimulus(1, 3, 1'b1);
    waitDone(lat, stalls);
    checkOutput("t5a_latency", 64'(lat), 64'd2);
    checkOutput("t5a_mask", 64'(active_mask[3]), 64'hC);
    checkOutput("t5a_mode", 64'(sub_mode[3]), 64'd1);
    exp_count++;
    extra = 0;
    repeat (6) begin
      tick();
      if (stall) extra++;
    end
    checkOutput("t5a_no_second_round", 64'(extra), 64'd0);
    checkOutput("t5a_count", 64'(count), 64'(exp_count));

    // T5 cont: second fault arrives in the SWAP cycle -> two rounds back to back
    applyStimulus(0, 4, 1'b1);
    tick();
    tick();
    tick();
    checkOutput("t5b_in_swap", 64'(stall), 64'd1);
    applyStimulus(1, 4, 1'b1);
    waitDone(lat, stalls);
    checkOutput("t5b_first_latency", 64'(lat), 64'd1);
    checkOutput("t5b_first_mask", 64'(active_mask[4]), 64'hE);
    checkOutput("t5b_first_mode", 64'(sub_mode[4]), 64'd0);
    exp_count++;
    tick();
    checkOutput("t5b_redrain_stall", 64'(stall), 64'd1);
    checkOutput("t5b_redrain_done", 64'(done), 64'd0);
    waitDone(lat, stalls);
    checkOutput("t5b_second_latency", 64'(lat), 64'd2);
    checkOutput("t5b_second_mask", 64'(active_mask[4]), 64'hC);
    checkOutput("t5b_second_mode", 64'(sub_mode[4]), 64'd1);
    exp_count++;
    tick();
    checkOutput("t5b_count", 64'(count), 64'(exp_count));

    // T6: dropping flags never re-enables an ALU, re-raising a seen flag is ignored
    flags[1][0] = 1'b0;
    flags[3][8] = 1'b0;
    extra = 0;
    repeat (6) begin
      tick();
      if (stall) extra++;
    end
    flags[3][8] = 1'b1;
    repeat (6) begin
      tick();
      if (stall) extra++;
    end
    checkOutput("t6_no_round", 64'(extra), 64'd0);
    checkOutput("t6_mask0", 64'(active_mask[0]), 64'h0);
    checkOutput("t6_mask8", 64'(active_mask[8]), 64'h3);
    checkOutput("t6_mode8", 64'(sub_mode[8]), 64'd1);
    checkOutput("t6_count", 64'(count), 64'(exp_count));

    // T6 cont: asynchronous reset in the middle of DRAIN
    applyStimulus(1, 6, 1'b0);
    tick();
    tick();
    checkOutput("t6_drain_before_rst", 64'(stall), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_stall", 64'(stall), 64'd0);
    checkOutput("t6_rst_mask", 64'(active_mask), 64'h777777777);
    checkOutput("t6_rst_mode", 64'(sub_mode), 64'd0);
    checkOutput("t6_rst_count", 64'(count), 64'd0);
    checkOutput("t6_rst_unrec", 64'(unrec), 64'd0);
    checkOutput("t6_rst_tmo", 64'(tmo), 64'd0);
    flags      = '0;
    pipe_empty = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    extra = 0;
    repeat (4) begin
      tick();
      if (stall) extra++;
    end
    checkOutput("t6_post_rst_idle", 64'(extra), 64'd0);
    checkOutput("t6_post_rst_mask", 64'(active_mask), 64'h777777777);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
